// File: rtl/quad_sampler_if.sv
// Control/status bundle between the host register bank, encoder counters and quad_sampler.
interface quad_sampler_if #(
    parameter int CNT_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 24
);
    logic                    en;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    snap_req;
    logic                    hold;
    logic                    irq_en;
    logic                    irq_clr;
    logic [CNT_WIDTH-1:0]    count0;
    logic [CNT_WIDTH-1:0]    count1;
    logic [CNT_WIDTH-1:0]    pos0;
    logic [CNT_WIDTH-1:0]    pos1;
    logic [CNT_WIDTH-1:0]    vel0;
    logic [CNT_WIDTH-1:0]    vel1;
    logic                    upd_valid;
    logic                    sample_irq;
    logic                    overrun;
    logic                    busy;

    modport master (
        output en, period, snap_req, hold, irq_en, irq_clr, count0, count1,
        input  pos0, pos1, vel0, vel1, upd_valid, sample_irq, overrun, busy
    );

    modport slave (
        input  en, period, snap_req, hold, irq_en, irq_clr, count0, count1,
        output pos0, pos1, vel0, vel1, upd_valid, sample_irq, overrun, busy
    );
endinterface

// File: rtl/quad_sampler.sv
// Periodic/manual snapshot of two encoder counts with signed per-period deltas,
// committed to the register bank through a single upd_valid pulse.

module quad_sampler_lane #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 hba_clk,
    input  logic                 hba_reset_n,
    input  logic                 load_base,
    input  logic                 capture,
    input  logic                 commit,
    input  logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] pos,
    output logic [CNT_WIDTH-1:0] vel
);
    logic [CNT_WIDTH-1:0] last;
    logic [CNT_WIDTH-1:0] sh_pos;
    logic [CNT_WIDTH-1:0] sh_vel;

    // Commit and capture may coincide; commit takes the pre-capture shadow.
    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            last   <= '0;
            sh_pos <= '0;
            sh_vel <= '0;
            pos    <= '0;
            vel    <= '0;
        end else begin
            if (load_base || capture) last <= count;
            if (capture) begin
                sh_pos <= count;
                sh_vel <= count - last;
            end
            if (commit) begin
                pos <= sh_pos;
                vel <= sh_vel;
            end
        end
    end
endmodule

module quad_sampler #(
    parameter int CNT_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 24
) (
    input logic           hba_clk,
    input logic           hba_reset_n,
    quad_sampler_if.slave bus
);
    localparam int NUM_LANES = 2;
    localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, PEND, COMMIT} state_t;

    state_t                  state, state_nx;
    logic [PERIOD_WIDTH-1:0] timer, timer_nx;
    logic                    terminal, trigger, commit, load_base, ovr_set;
    logic                    upd_valid, sample_irq, overrun;

    logic [NUM_LANES-1:0][CNT_WIDTH-1:0] cnt;
    logic [NUM_LANES-1:0][CNT_WIDTH-1:0] pos;
    logic [NUM_LANES-1:0][CNT_WIDTH-1:0] vel;

    assign cnt = {bus.count1, bus.count0};

    assign terminal  = (bus.period != '0) && (timer >= bus.period - ONE);
    assign trigger   = bus.en && (state != IDLE) && (terminal || bus.snap_req);
    assign commit    = bus.en && (state == PEND) && !bus.hold;
    assign load_base = bus.en && (state == IDLE);
    // Overwrite only counts when the old shadow is still uncommitted.
    assign ovr_set   = trigger && (state == PEND) && bus.hold;

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        if (!bus.en) begin
            state_nx = IDLE;
            timer_nx = '0;
        end else begin
            case (state)
                IDLE:    state_nx = RUN;
                RUN:     state_nx = trigger ? PEND : RUN;
                PEND:    if (!bus.hold) state_nx = trigger ? PEND : COMMIT;
                COMMIT:  state_nx = trigger ? PEND : RUN;
                default: state_nx = IDLE;
            endcase
            if (state == IDLE) timer_nx = '0;
            else               timer_nx = trigger ? '0 : timer + ONE;
        end
    end

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            upd_valid  <= 1'b0;
            sample_irq <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            upd_valid  <= commit;
            sample_irq <= (upd_valid && bus.irq_en) || (sample_irq && !bus.irq_clr);
            overrun    <= ovr_set || (overrun && !bus.irq_clr);
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        quad_sampler_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
            .hba_clk     (hba_clk),
            .hba_reset_n (hba_reset_n),
            .load_base   (load_base),
            .capture     (trigger),
            .commit      (commit),
            .count       (cnt[g]),
            .pos         (pos[g]),
            .vel         (vel[g])
        );
    end

    assign bus.pos0       = pos[0];
    assign bus.pos1       = pos[1];
    assign bus.vel0       = vel[0];
    assign bus.vel1       = vel[1];
    assign bus.upd_valid  = upd_valid;
    assign bus.sample_irq = sample_irq;
    assign bus.overrun    = overrun;
    assign bus.busy       = (state == PEND);
endmodule

// File: tb/tb_quad_sampler.sv
// Directed-vector bench for quad_sampler: periodic, wrap, hold/overrun, snapshots, irq, reset.
module tb_quad_sampler;
    logic hba_clk = 1'b0;
    logic hba_reset_n;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    quad_sampler_if #(.CNT_WIDTH(16), .PERIOD_WIDTH(24)) bus ();

    quad_sampler #(.CNT_WIDTH(16), .PERIOD_WIDTH(24)) dut (
        .hba_clk     (hba_clk),
        .hba_reset_n (hba_reset_n),
        .bus         (bus)
    );

    always #5 hba_clk = ~hba_clk;

    task automatic step();
        @(posedge hba_clk);
        #1;
    endtask

    // Steps until upd_valid is seen; n returns the number of edges taken.
    task automatic wait_upd(input int max, output int n);
        n = 0;
        do begin step(); n++; end while (!bus.upd_valid && n < max);
        chk_cnt++;
        if (bus.upd_valid !== 1'b1) $display("FAIL wait_upd: no upd_valid within %0d cycles", max);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        hba_reset_n = 1'b0;
        bus.en = 0; bus.period = 24'd10; bus.snap_req = 0; bus.hold = 0;
        bus.irq_en = 0; bus.irq_clr = 0; bus.count0 = 16'd77; bus.count1 = 16'd5;
        step(); step(); step();
        chk_cnt++;
        if ({bus.pos0, bus.pos1, bus.vel0, bus.vel1} !== 64'd0)
            $display("FAIL reset_data: got %h required 0", {bus.pos0, bus.pos1, bus.vel0, bus.vel1});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.upd_valid, bus.sample_irq, bus.overrun, bus.busy} !== 4'b0)
            $display("FAIL reset_flags: got %b required 0000", {bus.upd_valid, bus.sample_irq, bus.overrun, bus.busy});
        else pass_cnt++;
        hba_reset_n = 1'b1;
        step();
    endtask

    task automatic test_periodic();
        int n;
        bus.count0 = 16'd100; bus.count1 = 16'd0; bus.period = 24'd10; bus.en = 1'b1;
        step();
        bus.count0 = 16'd103;
        wait_upd(20, n);
        chk_cnt++;
        if (n !== 11) $display("FAIL periodic_first_lat: got %0d required 11", n); else pass_cnt++;
        chk_cnt++;
        if (bus.pos0 !== 16'd103 || bus.vel0 !== 16'd3)
            $display("FAIL periodic_first: pos0=%0d vel0=%0d required 103/3", bus.pos0, bus.vel0);
        else pass_cnt++;
        chk_cnt++;
        if (bus.pos1 !== 16'd0 || bus.vel1 !== 16'd0)
            $display("FAIL periodic_ch1: pos1=%0d vel1=%0d required 0/0", bus.pos1, bus.vel1);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (bus.upd_valid !== 1'b0) $display("FAIL periodic_pulse: upd_valid=%b required 0", bus.upd_valid);
        else pass_cnt++;
        for (int i = 2; i <= 3; i++) begin
            bus.count0 = 16'(100 + 3 * i);
            wait_upd(20, n);
            chk_cnt++;
            if (n !== ((i == 2) ? 9 : 10)) $display("FAIL periodic_interval%0d: got %0d", i, n);
            else pass_cnt++;
            chk_cnt++;
            if (bus.pos0 !== 16'(100 + 3 * i) || bus.vel0 !== 16'd3)
                $display("FAIL periodic_val%0d: pos0=%0d vel0=%0d required %0d/3", i, bus.pos0, bus.vel0, 100 + 3 * i);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        int n;
        bus.count0 = 16'hFFFE;
        wait_upd(20, n);
        bus.count0 = 16'h0003;
        wait_upd(20, n);
        chk_cnt++;
        if (bus.pos0 !== 16'h0003 || bus.vel0 !== 16'h0005)
            $display("FAIL wrap_up: pos0=%h vel0=%h required 0003/0005", bus.pos0, bus.vel0);
        else pass_cnt++;
        bus.count0 = 16'hFFFE;
        wait_upd(20, n);
        chk_cnt++;
        if (bus.pos0 !== 16'hFFFE || bus.vel0 !== 16'hFFFB)
            $display("FAIL wrap_down: pos0=%h vel0=%h required FFFE/FFFB", bus.pos0, bus.vel0);
        else pass_cnt++;
    endtask

    task automatic test_hold_overrun();
        int n;
        bit seen_upd;
        bus.count0 = 16'd40;
        wait_upd(20, n);
        bus.hold = 1'b1; bus.count0 = 16'd50; seen_upd = 0;
        n = 0;
        while (!bus.busy && n < 12) begin step(); n++; if (bus.upd_valid) seen_upd = 1; end
        chk_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL hold_busy: busy=%b required 1", bus.busy); else pass_cnt++;
        bus.count0 = 16'd80;
        n = 0;
        while (!bus.overrun && n < 12) begin step(); n++; if (bus.upd_valid) seen_upd = 1; end
        chk_cnt++;
        if (bus.overrun !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL hold_overrun: overrun=%b busy=%b required 1/1", bus.overrun, bus.busy);
        else pass_cnt++;
        chk_cnt++;
        if (seen_upd !== 1'b0) $display("FAIL hold_no_upd: upd_valid seen while held, required none");
        else pass_cnt++;
        bus.hold = 1'b0;
        step();
        chk_cnt++;
        if (bus.upd_valid !== 1'b1 || bus.pos0 !== 16'd80 || bus.vel0 !== 16'd30)
            $display("FAIL hold_release: upd=%b pos0=%0d vel0=%0d required 1/80/30", bus.upd_valid, bus.pos0, bus.vel0);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (bus.sample_irq !== 1'b0) $display("FAIL irq_gated: sample_irq=%b required 0", bus.sample_irq);
        else pass_cnt++;
        bus.irq_clr = 1'b1;
        step();
        bus.irq_clr = 1'b0;
        chk_cnt++;
        if (bus.overrun !== 1'b0) $display("FAIL overrun_clr: overrun=%b required 0", bus.overrun);
        else pass_cnt++;
    endtask

    task automatic test_snap();
        int n;
        int cnt;
        bus.count0 = 16'd150;
        wait_upd(20, n);
        step(); step(); step();
        bus.snap_req = 1'b1; bus.count0 = 16'd200;
        step();
        bus.snap_req = 1'b0; bus.count0 = 16'd999;
        chk_cnt++;
        if (bus.upd_valid !== 1'b0) $display("FAIL snap_early: upd_valid=%b required 0", bus.upd_valid);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (bus.upd_valid !== 1'b1 || bus.pos0 !== 16'd200 || bus.vel0 !== 16'd50)
            $display("FAIL snap_commit: upd=%b pos0=%0d vel0=%0d required 1/200/50", bus.upd_valid, bus.pos0, bus.vel0);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (bus.upd_valid !== 1'b0) $display("FAIL snap_pulse: upd_valid=%b required 0", bus.upd_valid);
        else pass_cnt++;
        wait_upd(20, n);
        chk_cnt++;
        if (n !== 9 || bus.pos0 !== 16'd999)
            $display("FAIL snap_rephase: interval=%0d pos0=%0d required 9/999", n, bus.pos0);
        else pass_cnt++;
        // Land snap_req on the terminal-count cycle.
        for (int i = 0; i < 8; i++) step();
        bus.snap_req = 1'b1;
        step();
        bus.snap_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 9; i++) begin step(); if (bus.upd_valid) cnt++; end
        chk_cnt++;
        if (cnt !== 1) $display("FAIL snap_coincident: got %0d upd pulses required 1", cnt); else pass_cnt++;
        wait_upd(20, n);
        chk_cnt++;
        if (n !== 2) $display("FAIL snap_coincident_period: got %0d required 2", n); else pass_cnt++;
    endtask

    task automatic test_irq();
        int n;
        bus.irq_en = 1'b1;
        wait_upd(20, n);
        step();
        chk_cnt++;
        if (bus.sample_irq !== 1'b1) $display("FAIL irq_set: sample_irq=%b required 1", bus.sample_irq);
        else pass_cnt++;
        bus.irq_clr = 1'b1;
        step();
        bus.irq_clr = 1'b0;
        chk_cnt++;
        if (bus.sample_irq !== 1'b0) $display("FAIL irq_clr: sample_irq=%b required 0", bus.sample_irq);
        else pass_cnt++;
        wait_upd(20, n);
        bus.irq_clr = 1'b1;
        step();
        bus.irq_clr = 1'b0;
        chk_cnt++;
        if (bus.sample_irq !== 1'b1) $display("FAIL irq_set_wins: sample_irq=%b required 1", bus.sample_irq);
        else pass_cnt++;
        bus.irq_clr = 1'b1;
        step();
        bus.irq_clr = 1'b0;
        chk_cnt++;
        if (bus.sample_irq !== 1'b0) $display("FAIL irq_clr2: sample_irq=%b required 0", bus.sample_irq);
        else pass_cnt++;
        bus.irq_en = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        int cnt;
        bus.hold = 1'b1;
        n = 0;
        while (!bus.busy && n < 12) begin step(); n++; end
        chk_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL areset_pend: busy=%b required 1", bus.busy); else pass_cnt++;
        #2;
        hba_reset_n = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.pos0, bus.vel0, bus.upd_valid, bus.busy} !== 34'd0)
            $display("FAIL areset_outputs: pos0=%0d vel0=%0d upd=%b busy=%b required 0", bus.pos0, bus.vel0, bus.upd_valid, bus.busy);
        else pass_cnt++;
        bus.hold = 1'b0; bus.period = 24'd0;
        step(); step();
        hba_reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin step(); if (bus.upd_valid) cnt++; end
        chk_cnt++;
        if (cnt !== 0) $display("FAIL period_zero: got %0d upd pulses required 0", cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_wrap();
        test_hold_overrun();
        test_snap();
        test_irq();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/quad_sampler.md
Name: quad_sampler

Overview:
Periodic snapshot scheduler for the dual quadrature encoder datapath. It samples both free-running 16-bit encoder counts in the same clock cycle, computes a signed per-period delta (velocity) for each, and commits position and velocity to the register bank through a single write-enable pulse. Commits are deferred while the host holds the bank for reading. It sits between the two pulse counters and the HBA register banks, and drives the peripheral interrupt.

Parameters:
CNT_WIDTH, 16, width of each encoder count, position output and velocity output
PERIOD_WIDTH, 24, width of the sample period register in hba_clk cycles

Ports:
hba_clk  in  1  peripheral clock; all logic on rising edge
hba_reset_n  in  1  reset, asynchronous, active-low
en  in  1  sampler enable (control register bit)
period  in  PERIOD_WIDTH  sample period in clocks; 0 = periodic sampling off, manual snapshots only
snap_req  in  1  single-cycle manual snapshot request
hold  in  1  host read-in-progress; while 1, no commits occur
irq_en  in  1  interrupt enable
irq_clr  in  1  single-cycle clear of sample_irq and overrun
count0, count1  in  CNT_WIDTH  live encoder counts (two's-complement, wrapping)
pos0, pos1  out  CNT_WIDTH  committed positions
vel0, vel1  out  CNT_WIDTH  committed signed deltas since the previous capture
upd_valid  out  1  one-cycle pulse; new pos/vel present (drives register bank slv_wr_en)
sample_irq  out  1  sticky sample-committed flag, gated by irq_en
overrun  out  1  sticky; a pending uncommitted sample was overwritten
busy  out  1  high in PEND

Behaviour:
- Reset: all outputs 0; timer 0; last0/last1 0; state IDLE.
- States: IDLE, RUN, PEND, COMMIT.
- IDLE: while en=0, stay in IDLE with timer held at 0. On en 0->1, load last0/last1 from count0/count1 (baseline), then go to RUN. The first delta is measured from this baseline.
- Trigger in RUN/PEND: timer is nonzero-period and timer >= period-1 (terminal), or snap_req=1. Simultaneous terminal and snap_req produce one capture.
- Timer: increments each cycle in RUN/PEND/COMMIT. It resets to 0 on terminal or snap_req, so snap_req rephases the period. If period is lowered below the current timer value, the next cycle is terminal. With period=1, every cycle is a trigger.
- Capture at the end of trigger cycle N:
  - sh_pos <= count; sh_vel <= count - last (mod 2^CNT_WIDTH; wrap yields the correct signed delta for |delta| < 2^(CNT_WIDTH-1)).
  - last <= count.
- After capture: if hold=0 in cycle N+1, then at the end of N+1 pos/vel <= shadow, upd_valid <= 1 (visible in cycle N+2 together with the new values, state COMMIT). Otherwise go to PEND.
- PEND: on the first cycle with hold=0, commit as above. A new trigger while in PEND overwrites the shadow with the newest capture (vel = new count - previous capture) and sets overrun.
- COMMIT: lasts one cycle; upd_valid=1; then return to RUN. A trigger during COMMIT is a normal capture.
- upd_valid is never high for 2 consecutive cycles unless triggers are consecutive (period=1, hold=0).
- sample_irq: set when upd_valid is asserted and irq_en=1. Cleared by irq_clr. Set wins over a same-cycle clear. overrun follows the same set/clear rule, with no irq_en gating.
- en 1->0 in any state: next state IDLE; pending shadow discarded; pos/vel/flags retained; upd_valid 0.
- hba_reset_n low asynchronously forces the reset values mid-operation. Deassertion is synchronised externally.

Test Plan:
- Reset: hba_reset_n=0 mid-PEND -> all outputs 0 immediately; after release, en=1, period=0 -> no upd_valid for 1000 cycles.
- Periodic: en rises with count0=100; period=10; count0 increments by 3 per period -> upd_valid every 10 cycles, pos0=103,106,..., vel0=3. count1 held at 0 -> vel1=0.
- Wrap/sign: count0 goes 0xFFFE -> 0x0003 across one period -> vel0=0x0005. Reverse, 0x0003 -> 0xFFFE -> vel0=0xFFFB (-5).
- Hold/overrun: hold=1 across 2 triggers with counts 50 then 80 (previous capture 40) -> no upd_valid, busy=1, overrun=1. On hold=0 -> one upd_valid, pos=80, vel=30.
- snap_req at timer=4 with period=10 -> capture in that cycle, upd_valid 2 cycles later, next periodic trigger 10 cycles after the snap. snap_req coincident with terminal -> exactly one upd_valid.
- Interrupt: irq_en=1, commit -> sample_irq=1. irq_clr in the same cycle as the next commit -> sample_irq stays 1. irq_clr alone -> 0. irq_en=0 -> sample_irq never sets.
